// File: rtl/uart_tx_ctl_pkg.sv
// Shared definitions for the s3 UART transmitter: register offsets, STATUS/CTRL
// bit positions, FSM encodings and the bit-period reload helper.
package uart_tx_ctl_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_LVL_LSB = 8;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // A divisor of 0 behaves as 1, so the reload is max(div,1)-1.
   function automatic logic [15:0] bit_reload(input logic [15:0] div);
      return (div == 16'd0) ? 16'd0 : div - 16'd1;
   endfunction

endpackage

// File: rtl/uart_tx_ctl_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit so that
// level = wr - rd distinguishes full from empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign level   = wr_ptr - rd_ptr;
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign dout    = mem[rd_ptr[AW-1:0]];
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop) && !flush;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_tx_ctl.sv
// Memory-mapped 8N1 UART transmitter on bus slot s3: register file, registered
// read mux, TX FIFO and the serialiser FSM with its baud down-counter.
module uart_tx_ctl
   import uart_tx_ctl_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   output logic [15:0] di,
   input  logic        we,
   input  logic [15:0] a,
   input  logic [15:0] do_data,  // bus write data; "do" is a reserved word in SystemVerilog
   output logic        uart_tx
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]    sel;
   logic          wr_data, wr_status, wr_div, wr_ctrl;
   logic [15:0]   divisor;
   logic          enable;
   logic          overflow;
   logic          flush_q;

   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [LW-1:0] fifo_level;

   logic [1:0]    state;
   logic [15:0]   bit_cnt;
   logic [15:0]   bit_rld;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          line_next;
   logic [15:0]   status_word;
   logic [15:0]   rd_mux;
   logic          unused_addr_bits;

   assign sel       = a[2:1];
   assign wr_data   = we && (sel == REG_DATA);
   assign wr_status = we && (sel == REG_STATUS);
   assign wr_div    = we && (sel == REG_DIV);
   assign wr_ctrl   = we && (sel == REG_CTRL);
   assign unused_addr_bits = ^{a[15:3], a[0]};

   // Flush is applied one edge after the CTRL write; no frame starts on that edge.
   assign fifo_pop = (state == S_IDLE) && enable && !fifo_empty && !flush_q;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .push    (wr_data),
      .din     (do_data[7:0]),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .flush   (flush_q),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // NOTE: every combinational output gets a default first so no latch can be inferred.
   always_comb begin
      status_word                      = '0;
      status_word[ST_BUSY]             = (state != S_IDLE);
      status_word[ST_FULL]             = fifo_full;
      status_word[ST_EMPTY]            = fifo_empty;
      status_word[ST_OVF]              = overflow;
      status_word[ST_LVL_LSB +: 5]     = 5'(fifo_level);
      rd_mux = '0;
      case (sel)
         REG_STATUS: rd_mux = status_word;
         REG_DIV:    rd_mux = divisor;
         REG_CTRL:   rd_mux = {15'd0, enable};
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         di       <= '0;
         divisor  <= DEFAULT_DIV;
         enable   <= 1'b1;
         overflow <= 1'b0;
         flush_q  <= 1'b0;
      end else begin
         di      <= rd_mux;
         flush_q <= wr_ctrl && do_data[CTRL_FLUSH];
         if (wr_div)  divisor <= do_data;
         if (wr_ctrl) enable  <= do_data[CTRL_EN];
         if (wr_status && do_data[ST_OVF])
            overflow <= 1'b0;
         else if (wr_data && fifo_full && !fifo_pop && !flush_q)
            overflow <= 1'b1;
      end
   end

   // The line is registered from the current state, so it lags the FSM by one cycle.
   always_comb begin
      line_next = 1'b1;
      case (state)
         S_START: line_next = 1'b0;
         S_DATA:  line_next = shift[0];
         default: line_next = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         bit_rld <= '0;
         bit_idx <= '0;
         shift   <= '0;
         uart_tx <= 1'b1;
      end else begin
         uart_tx <= line_next;
         case (state)
            S_IDLE: begin
               if (fifo_pop) begin
                  shift   <= fifo_dout;
                  bit_rld <= bit_reload(divisor);
                  bit_cnt <= bit_reload(divisor);
                  bit_idx <= '0;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (bit_cnt == '0) begin
                  bit_cnt <= bit_rld;
                  state   <= S_DATA;
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (bit_cnt == '0) begin
                  bit_cnt <= bit_rld;
                  shift   <= {1'b0, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= S_STOP;
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            default: begin
               if (bit_cnt == '0) state <= S_IDLE;
               else               bit_cnt <= bit_cnt - 16'd1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Bench for uart_tx_ctl: register vectors, a frame-timing reference model driven
// by random bytes/divisors, and hand-written overflow, flush and reset sequences.
module tb_uart_tx_ctl;
   import uart_tx_ctl_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        we      = 1'b0;
   logic [15:0] a       = '0;
   logic [15:0] do_data = '0;
   logic [15:0] di;
   logic        uart_tx;

   uart_tx_ctl #(.FIFO_DEPTH(16), .DEFAULT_DIV(16'd868)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .di      (di),
      .we      (we),
      .a       (a),
      .do_data (do_data),
      .uart_tx (uart_tx)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] addr(input logic [1:0] s);
      return 16'hc000 | {13'd0, s, 1'b0};
   endfunction

   task automatic bus_write(input logic [1:0] s, input logic [15:0] d);
      @(negedge sys_clk);
      we = 1'b1; a = addr(s); do_data = d;
      @(negedge sys_clk);
      we = 1'b0;
   endtask

   task automatic write2(input logic [1:0] s0, input logic [15:0] d0,
                         input logic [1:0] s1, input logic [15:0] d1);
      @(negedge sys_clk);
      we = 1'b1; a = addr(s0); do_data = d0;
      @(negedge sys_clk);
      a = addr(s1); do_data = d1;
      @(negedge sys_clk);
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] s, output logic [15:0] v);
      @(negedge sys_clk);
      we = 1'b0; a = addr(s);
      @(negedge sys_clk);
      v = di;
   endtask

   // Reference model: frame i begins (line low) at offset s_i from the first
   // push edge; s_0 = 2, each frame is 10 bit periods plus one idle cycle.
   bit         mon_on = 1'b0;
   int         mon_base, mon_n, mon_stat_k;
   logic [7:0] mon_bytes [20];
   int         mon_divs  [20];

   function automatic logic exp_line(input int t);
      int s = 2;
      for (int i = 0; i < mon_n; i++) begin
         int len = 10 * mon_divs[i];
         if (t >= s && t < s + len) begin
            int b = (t - s) / mon_divs[i];
            if (b == 0) return 1'b0;
            if (b == 9) return 1'b1;
            return mon_bytes[i][b-1];
         end
         s += len + 1;
      end
      return 1'b1;
   endfunction

   function automatic logic exp_busy(input int t);
      int s = 2;
      for (int i = 0; i < mon_n; i++) begin
         int len = 10 * mon_divs[i];
         if (t >= s && t < s + len) return 1'b1;
         s += len + 1;
      end
      return 1'b0;
   endfunction

   function automatic int stream_len();
      int s = 2;
      for (int i = 0; i < mon_n; i++) s += 10 * mon_divs[i] + 1;
      return s + 3;
   endfunction

   always @(negedge sys_clk) begin
      if (mon_on && cyc > mon_base) begin
         check("uart_tx", 16'(uart_tx), 16'(exp_line(cyc - mon_base)));
         if (cyc >= mon_stat_k)
            check("busy", 16'(di[ST_BUSY]), 16'(exp_busy(cyc - mon_base)));
      end
   end

   // Pushes nb bytes on consecutive edges; the model expects nframes frames.
   task automatic run_stream(input int nb, input int nframes, input bit stat_chk);
      @(negedge sys_clk);
      mon_base   = cyc + 1;
      mon_n      = nframes;
      mon_stat_k = stat_chk ? mon_base + nb : 32'h3fff_ffff;
      mon_on     = 1'b1;
      for (int i = 0; i < nb; i++) begin
         if (i > 0) @(negedge sys_clk);
         we = 1'b1; a = addr(REG_DATA); do_data = {8'd0, mon_bytes[i]};
      end
      @(negedge sys_clk);
      we = 1'b0; a = addr(REG_STATUS);
   endtask

   task automatic wait_stream();
      int end_k = mon_base + stream_len();
      while (cyc < end_k) @(negedge sys_clk);
      mon_on = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [1:0]  sel;
      logic [15:0] wdata;
      logic [15:0] rexp;
   } vec_t;

   vec_t        vecs [7];
   logic [15:0] v;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"div_rw",       REG_DIV,    16'h1234, 16'h1234};
      vecs[1] = '{"div_zero",     REG_DIV,    16'h0000, 16'h0000};
      vecs[2] = '{"div_ones",     REG_DIV,    16'hffff, 16'hffff};
      vecs[3] = '{"ctrl_dis",     REG_CTRL,   16'hfffe, 16'h0000};
      vecs[4] = '{"ctrl_en",      REG_CTRL,   16'h0003, 16'h0001};
      vecs[5] = '{"status_ro",    REG_STATUS, 16'hfff7, 16'h0004};
      vecs[6] = '{"data_rd0",     REG_DATA,   16'h0000, 16'h0000};

      // Reset state.
      repeat (3) begin
         @(negedge sys_clk);
         check("rst_uart_tx", 16'(uart_tx), 16'h0001);
      end
      check("rst_di", di, 16'h0000);
      sys_rst = 1'b0;
      bus_read(REG_STATUS, v); check("rst_status", v, 16'h0004);
      bus_read(REG_DIV, v);    check("rst_div", v, 16'd868);
      bus_read(REG_CTRL, v);   check("rst_ctrl", v, 16'h0001);
      bus_read(REG_DATA, v);   check("rst_data", v, 16'h0000);
      check("idle_uart_tx", 16'(uart_tx), 16'h0001);

      // Register vectors; the DATA entry is only read, never written.
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].sel != REG_DATA) bus_write(vecs[i].sel, vecs[i].wdata);
         bus_read(vecs[i].sel, v);
         check(vecs[i].name, v, vecs[i].rexp);
      end

      // Single frame, 4-cycle bits.
      bus_write(REG_DIV, 16'd4);
      mon_bytes[0] = 8'h55; mon_divs[0] = 4;
      run_stream(1, 1, 1'b1);
      wait_stream();

      // Back-to-back frames at divisor 1.
      bus_write(REG_DIV, 16'd1);
      mon_bytes[0] = 8'ha3; mon_divs[0] = 1;
      mon_bytes[1] = 8'h0f; mon_divs[1] = 1;
      run_stream(2, 2, 1'b1);
      wait_stream();

      // Divisor change mid-frame applies only to the next frame.
      bus_write(REG_DIV, 16'd8);
      mon_bytes[0] = 8'hc6; mon_divs[0] = 8;
      mon_bytes[1] = 8'h3b; mon_divs[1] = 2;
      run_stream(2, 2, 1'b0);
      repeat (20) @(negedge sys_clk);
      bus_write(REG_DIV, 16'd2);
      wait_stream();

      // Overflow with transmitter disabled; the line must stay idle.
      bus_write(REG_CTRL, 16'h0000);
      for (int i = 0; i < 17; i++) mon_bytes[i] = 8'(i + 1);
      run_stream(17, 0, 1'b0);
      bus_read(REG_STATUS, v);  check("ovf_status", v, 16'h100a);
      bus_write(REG_STATUS, 16'h0008);
      bus_read(REG_STATUS, v);  check("ovf_clear", v, 16'h1002);
      mon_on = 1'b0;
      // Enable then push on the next edge: pop and push coincide while full.
      write2(REG_CTRL, 16'h0001, REG_DATA, 16'h0099);
      bus_read(REG_STATUS, v);  check("full_pop_push", v, 16'h1003);
      bus_write(REG_CTRL, 16'h0003);
      repeat (30) @(negedge sys_clk);
      bus_read(REG_STATUS, v);  check("flush_empty", v, 16'h0004);
      write2(REG_CTRL, 16'h0002, REG_DATA, 16'h0077);
      bus_read(REG_STATUS, v);  check("flush_push_drop", v, 16'h0004);
      bus_write(REG_CTRL, 16'h0001);
      bus_read(REG_CTRL, v);    check("ctrl_reenable", v, 16'h0001);

      // Randomised frames, including divisor 0 (behaves as 1).
      for (int it = 0; it < 6; it++) begin
         int raw = $urandom_range(0, 4);
         int nb  = $urandom_range(1, 4);
         bus_write(REG_DIV, 16'(raw));
         for (int i = 0; i < nb; i++) begin
            mon_bytes[i] = 8'($urandom);
            mon_divs[i]  = (raw == 0) ? 1 : raw;
         end
         run_stream(nb, nb, 1'b1);
         wait_stream();
      end

      // Reset during the DATA state.
      bus_write(REG_DIV, 16'd4);
      write2(REG_DATA, 16'h0000, REG_DATA, 16'h0081);
      repeat (7) @(negedge sys_clk);
      check("pre_rst_data_bit", 16'(uart_tx), 16'h0000);
      sys_rst = 1'b1; a = addr(REG_STATUS);
      @(negedge sys_clk);
      check("mid_rst_uart_tx", 16'(uart_tx), 16'h0001);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check("mid_rst_status", di, 16'h0004);
      bus_read(REG_DIV, v);  check("mid_rst_div", v, 16'd868);
      repeat (20) begin
         @(negedge sys_clk);
         check("post_rst_idle", 16'(uart_tx), 16'h0001);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
